// File: rtl/branch_predict_ctrl.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts next PC in IF, resolves in ID, and keeps branch/mispredict statistics.
module branch_predict_ctrl #(
   parameter int         IDX_W    = 4,
   parameter logic [1:0] INIT_CNT = 2'b01,
   parameter int         STAT_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic [31:0]       pc_if_i,
   output logic              pred_taken_o,
   output logic [31:0]       pred_pc_o,
   input  logic [31:0]       pc_id_i,
   input  logic              branch_i,
   input  logic              taken_i,
   input  logic [31:0]       target_id_i,
   output logic              flush_o,
   output logic [31:0]       redirect_pc_o,
   output logic [STAT_W-1:0] branch_cnt_o,
   output logic [STAT_W-1:0] mispred_cnt_o
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 32 - IDX_W - 2;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         cnt_q    [ENTRIES];

   logic              pred_taken_q;
   logic [31:0]       pred_target_q;
   logic [STAT_W-1:0] branch_cnt_q;
   logic [STAT_W-1:0] mispred_cnt_q;

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;
   logic [IDX_W-1:0] id_idx;
   logic [TAG_W-1:0] id_tag;
   logic             id_hit;
   logic             resolve_en;
   logic             do_update;

   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
      if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
      else    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
   endfunction

   // IF lookup reads the pre-edge table; a same-cycle update is not bypassed.
   always_comb begin
      if_idx       = pc_if_i[IDX_W+1:2];
      if_tag       = pc_if_i[31:IDX_W+2];
      if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken_o = if_hit && cnt_q[if_idx][1];
      pred_pc_o    = pred_taken_o ? target_q[if_idx] : pc_if_i + 32'd4;
   end

   always_comb begin
      id_idx     = pc_id_i[IDX_W+1:2];
      id_tag     = pc_id_i[31:IDX_W+2];
      id_hit     = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
      // Reset is folded in so flush/redirect read 0 while rst_i is low.
      resolve_en = rst_i && !stall_i;
      do_update  = resolve_en && branch_i;
   end

   always_comb begin
      flush_o       = 1'b0;
      redirect_pc_o = 32'd0;
      if (resolve_en) begin
         if (branch_i && taken_i && (!pred_taken_q || (pred_target_q != target_id_i))) begin
            flush_o       = 1'b1;
            redirect_pc_o = target_id_i;
         end else if (pred_taken_q && !(branch_i && taken_i)) begin
            // Predicted-taken non-branch (alias) or taken-predicted branch that fell through.
            flush_o       = 1'b1;
            redirect_pc_o = pc_id_i + 32'd4;
         end
      end
   end

   // NOTE: the table is small and register-based, so every entry gets an async reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= INIT_CNT;
         end
      end else if (do_update) begin
         if (id_hit) begin
            cnt_q[id_idx] <= sat_step(cnt_q[id_idx], taken_i);
            if (taken_i) target_q[id_idx] <= target_id_i;
         end else if (taken_i) begin
            valid_q[id_idx]  <= 1'b1;
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= target_id_i;
            cnt_q[id_idx]    <= INIT_CNT + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pred_taken_q  <= 1'b0;
         pred_target_q <= 32'd0;
      end else if (!stall_i) begin
         if (flush_o) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
         end else begin
            pred_taken_q  <= pred_taken_o;
            pred_target_q <= pred_taken_o ? target_q[if_idx] : 32'd0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (do_update) branch_cnt_q  <= branch_cnt_q + STAT_W'(1);
         if (flush_o)   mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl: allocation, counter
// saturation, not-taken and alias mispredicts, target change, stall and async reset.
module tb_branch_predict_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic [31:0] pc_if_i;
   logic        pred_taken_o;
   logic [31:0] pred_pc_o;
   logic [31:0] pc_id_i;
   logic        branch_i;
   logic        taken_i;
   logic [31:0] target_id_i;
   logic        flush_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispred_cnt_o;

   int passed = 0;
   int total  = 0;

   branch_predict_ctrl #(.IDX_W(4), .INIT_CNT(2'b01), .STAT_W(32)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .pc_if_i       (pc_if_i),
      .pred_taken_o  (pred_taken_o),
      .pred_pc_o     (pred_pc_o),
      .pc_id_i       (pc_id_i),
      .branch_i      (branch_i),
      .taken_i       (taken_i),
      .target_id_i   (target_id_i),
      .flush_o       (flush_o),
      .redirect_pc_o (redirect_pc_o),
      .branch_cnt_o  (branch_cnt_o),
      .mispred_cnt_o (mispred_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   // One cycle: drive IF and ID inputs after the falling edge, settle, then return for checks.
   task automatic cyc(input logic [31:0] pif, input logic st, input logic [31:0] pid,
                      input logic br, input logic tk, input logic [31:0] tgt);
      @(negedge clk);
      pc_if_i     = pif;
      stall_i     = st;
      pc_id_i     = pid;
      branch_i    = br;
      taken_i     = tk;
      target_id_i = tgt;
      #1;
   endtask

   task automatic check_pred(input string tag, input logic tk, input logic [31:0] pc);
      check({tag, "_pred_taken"}, {31'd0, pred_taken_o}, {31'd0, tk});
      check({tag, "_pred_pc"}, pred_pc_o, pc);
   endtask

   task automatic check_flush(input string tag, input logic fl, input logic [31:0] pc);
      check({tag, "_flush"}, {31'd0, flush_o}, {31'd0, fl});
      check({tag, "_redirect"}, redirect_pc_o, pc);
   endtask

   task automatic check_cnt(input string tag, input int br, input int mp);
      check({tag, "_branch_cnt"}, branch_cnt_o, br);
      check({tag, "_mispred_cnt"}, mispred_cnt_o, mp);
   endtask

   initial begin
      rst_i       = 1'b0;
      stall_i     = 1'b0;
      pc_if_i     = 32'h40;
      pc_id_i     = 32'h40;
      branch_i    = 1'b1;
      taken_i     = 1'b1;
      target_id_i = 32'h80;
      #2;
      check_pred("reset", 1'b0, 32'h44);
      check_flush("reset", 1'b0, 32'h0);
      check_cnt("reset", 0, 0);

      @(negedge clk);
      rst_i    = 1'b1;
      branch_i = 1'b0;
      taken_i  = 1'b0;

      // 1: cold miss on 0x40, resolves taken to 0x80
      cyc(32'h44, 1'b0, 32'h40, 1'b1, 1'b1, 32'h80);
      check_flush("alloc", 1'b1, 32'h80);
      check("alloc_if", {31'd0, pred_taken_o}, 32'd0);
      cyc(32'h40, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0);
      check_pred("after_alloc", 1'b1, 32'h80);
      check_flush("after_alloc", 1'b0, 32'h0);
      check_cnt("after_alloc", 1, 1);

      // 2: two correctly predicted taken resolutions, counter 10 -> 11 -> 11
      cyc(32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 32'h80);
      check_flush("hit_taken1", 1'b0, 32'h0);
      cyc(32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 32'h80);
      check_flush("hit_taken2", 1'b0, 32'h0);

      // 3: not taken while predicted taken, 11 -> 10 still predicts taken, then 10 -> 01
      cyc(32'h40, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
      check_cnt("after_taken", 3, 1);
      check_flush("nt1", 1'b1, 32'h44);
      cyc(32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0);
      check_pred("cnt_10", 1'b1, 32'h80);
      check_flush("bubble", 1'b0, 32'h0);
      cyc(32'h40, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
      check_flush("nt2", 1'b1, 32'h44);
      check_pred("no_bypass", 1'b1, 32'h80);
      cyc(32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0);
      check_pred("cnt_01", 1'b0, 32'h44);
      check_cnt("after_nt", 5, 3);

      // retrain: predicted not taken, resolves taken -> flush, counter 01 -> 10
      cyc(32'h84, 1'b0, 32'h40, 1'b1, 1'b1, 32'h80);
      check_flush("retrain", 1'b1, 32'h80);
      check_pred("other_idx", 1'b0, 32'h88);
      cyc(32'h40, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0);
      check_pred("retrained", 1'b1, 32'h80);

      // 4: predicted taken but instruction in ID is not a branch
      cyc(32'h40, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
      check_flush("alias", 1'b1, 32'h44);
      cyc(32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0);
      check_pred("alias_unchanged", 1'b1, 32'h80);
      check_cnt("after_alias", 6, 5);

      // 5: predicted 0x80, resolves taken to 0xC0
      cyc(32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 32'hC0);
      check_flush("target_chg", 1'b1, 32'hC0);
      check("target_chg_if_pre_edge", pred_pc_o, 32'h80);
      cyc(32'h40, 1'b0, 32'hC0, 1'b0, 1'b0, 32'h0);
      check_pred("new_target", 1'b1, 32'hC0);

      // 6: stalled mispredicting branch does nothing until released
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
      check_flush("stall1", 1'b0, 32'h0);
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
      check_flush("stall2", 1'b0, 32'h0);
      check_cnt("stall", 7, 6);
      check_pred("stall_table", 1'b1, 32'hC0);
      cyc(32'h40, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
      check_flush("unstall", 1'b1, 32'h44);
      cyc(32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0);
      check_flush("unstall_once", 1'b0, 32'h0);
      check_cnt("unstall", 8, 7);
      check_pred("unstall_cnt_10", 1'b1, 32'hC0);

      // asynchronous reset in the middle of a cycle with a pending flush
      @(negedge clk);
      pc_id_i     = 32'h40;
      branch_i    = 1'b1;
      taken_i     = 1'b1;
      target_id_i = 32'h80;
      #1;
      check_flush("pre_rst", 1'b1, 32'h80);
      #1;
      rst_i = 1'b0;
      #1;
      check_flush("mid_rst", 1'b0, 32'h0);
      check_cnt("mid_rst", 0, 0);
      check_pred("mid_rst", 1'b0, 32'h44);
      @(negedge clk);
      rst_i    = 1'b1;
      branch_i = 1'b0;
      taken_i  = 1'b0;
      cyc(32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0);
      check_pred("cold", 1'b0, 32'h44);
      check_flush("cold", 1'b0, 32'h0);
      check_cnt("cold", 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
